// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST: FSM states, element encoding
// and the per-element March table.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t E0 = 3'd0;
  localparam elem_t E1 = 3'd1;
  localparam elem_t E2 = 3'd2;
  localparam elem_t E3 = 3'd3;
  localparam elem_t E4 = 3'd4;
  localparam elem_t E5 = 3'd5;

  // rd_inv/wr_inv select ~BG instead of BG for the read expectation / write data.
  typedef struct packed {
    logic down;
    logic rd_inv;
    logic wr_inv;
    logic has_rd;
    logic has_wr;
  } march_op_t;

  function automatic march_op_t march_op(elem_t e);
    march_op_t op;
    op = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b0};
    case (e)
      E0: op = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
      E1: op = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      E2: op = '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      E3: op = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      E4: op = '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      E5: op = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
      default: ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-compare delay line: carries each issued read's payload for RD_LAT
// cycles so it lines up with the SRAM read data.
module mbist_cmp_pipe #(
  parameter int RD_LAT = 1,
  parameter int PW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [PW-1:0] push_data,
  output logic          pop_vld,
  output logic [PW-1:0] pop_data
);

  logic          vld_p  [RD_LAT];
  logic [PW-1:0] data_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= push_vld;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Payload is qualified by vld_p, so it needs no reset.
  always_ff @(posedge clk) begin
    data_p[0] <= push_data;
    for (int i = 1; i < RD_LAT; i++) data_p[i] <= data_p[i-1];
  end

  assign pop_vld  = vld_p[RD_LAT-1];
  assign pop_data = data_p[RD_LAT-1];

endmodule

// File: rtl/mbist_march.sv
// March C- memory BIST controller with functional/BIST SRAM request mux,
// delayed read compare and first-failure capture.
module mbist_march
  import mbist_pkg::*;
#(
  parameter int              DW           = 8,
  parameter int              AW           = 13,
  parameter int              RD_LAT       = 1,
  parameter logic [DW-1:0]   BG           = '0,
  parameter bit              STOP_ON_FAIL = 1'b0
) (
  input  logic          b_clk,
  input  logic          b_rst,
  input  logic          b_en,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  input  logic          wen,
  input  logic          csn,
  input  logic [DW-1:0] sram_data_in,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] wdata_out,
  output logic          wen_out,
  output logic          csn_out,
  output logic          b_done,
  output logic          b_fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem
);

  localparam int       PW         = DW + AW + 3;
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT - 1);

  state_t        state, state_nxt;
  elem_t         elem;
  logic [AW-1:0] addr;
  logic          phase;
  logic [2:0]    drain_cnt;
  logic          en_q;

  march_op_t     op;
  logic          in_run, is_rd, is_wr, step_done, at_term, last_issue, start;
  logic [DW-1:0] exp_data;

  logic          pop_vld;
  logic [PW-1:0] pop_data;
  logic [DW-1:0] cmp_exp;
  logic [AW-1:0] cmp_addr;
  elem_t         cmp_elem;
  logic          miscmp;

  assign op         = march_op(elem);
  assign in_run     = (state == RUN);
  // Read/write elements spend phase 0 reading and phase 1 writing the same address.
  assign is_rd      = op.has_rd && (!op.has_wr || !phase);
  assign is_wr      = op.has_wr && (!op.has_rd || phase);
  assign step_done  = !(op.has_rd && op.has_wr) || phase;
  assign at_term    = op.down ? (addr == '0) : (addr == '1);
  assign last_issue = (elem == E5) && at_term && step_done;
  assign start      = b_en && !en_q;
  assign exp_data   = op.rd_inv ? ~BG : BG;

  mbist_cmp_pipe #(
    .RD_LAT (RD_LAT),
    .PW     (PW)
  ) u_cmp_pipe (
    .clk       (b_clk),
    .rst       (b_rst || !b_en),
    .push_vld  (in_run && is_rd),
    .push_data ({exp_data, addr, elem}),
    .pop_vld   (pop_vld),
    .pop_data  (pop_data)
  );

  assign {cmp_exp, cmp_addr, cmp_elem} = pop_data;
  assign miscmp = pop_vld && (sram_data_in != cmp_exp);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if ((STOP_ON_FAIL && miscmp) || last_issue) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (!b_en) state_nxt = IDLE;
  end

  always_ff @(posedge b_clk) begin
    if (b_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Held high through reset so a level-high b_en never starts a test on release.
  always_ff @(posedge b_clk) begin
    en_q <= b_rst || b_en;
  end

  always_ff @(posedge b_clk) begin
    if (b_rst || state == IDLE) begin
      elem  <= E0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (in_run) begin
      if (!step_done) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (at_term) begin
          if (elem != E5) begin
            elem <= elem_t'(elem + 3'd1);
            addr <= march_op(elem_t'(elem + 3'd1)).down ? '1 : '0;
          end
        end else begin
          addr <= op.down ? addr - 1'b1 : addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge b_clk) begin
    if (b_rst || state != DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + 3'd1;
  end

  always_ff @(posedge b_clk) begin
    if (b_rst) b_done <= 1'b0;
    else       b_done <= b_en && (state == DONE);
  end

  // Only the first miscompare is recorded; abort or reset clears the record.
  always_ff @(posedge b_clk) begin
    if (b_rst || !b_en) begin
      b_fail    <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else if (miscmp && !b_fail) begin
      b_fail    <= 1'b1;
      fail_addr <= cmp_addr;
      fail_elem <= cmp_elem;
    end
  end

  always_comb begin
    addr_out  = addr_in;
    wdata_out = wdata_in;
    wen_out   = wen;
    csn_out   = csn;
    if (b_en) begin
      addr_out  = addr;
      wdata_out = op.wr_inv ? ~BG : BG;
      wen_out   = !(in_run && is_wr);
      csn_out   = !in_run;
    end
  end

endmodule

// File: doc/mbist_march.md
MBIST_MARCH -- requirements
Module: mbist_march

Interface
REQ-001 The block SHALL have parameter DW, default 8, SRAM data width.
REQ-002 The block SHALL have parameter AW, default 13, SRAM address width; depth = 2^AW.
REQ-003 The block SHALL have parameter RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-004 The block SHALL have parameter BG, default all-zeros, DW-bit data background; its complement is ~BG.
REQ-005 The block SHALL have parameter STOP_ON_FAIL, default 0; 1 = stop at the first miscompare.
REQ-006 b_clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 b_rst  in  1  synchronous, active-high reset.
REQ-008 b_en  in  1  BIST mode; a 0->1 transition starts a test, and a level of 0 selects the functional path.
REQ-009 addr_in / wdata_in / wen / csn  in  AW / DW / 1 / 1  functional SRAM request (wen low = write, csn low = select).
REQ-010 sram_data_in  in  DW  SRAM read data.
REQ-011 addr_out / wdata_out / wen_out / csn_out  out  AW / DW / 1 / 1  muxed SRAM request.
REQ-012 b_done  out  1  test finished.
REQ-013 b_fail  out  1  sticky miscompare flag.
REQ-014 fail_addr  out  AW  address of the first miscompare.
REQ-015 fail_elem  out  3  March element index (0..5) of the first miscompare.

Function
REQ-016 The mux SHALL be combinational: when b_en=0, outputs equal the functional inputs; when b_en=1, outputs are BIST-driven, with csn_out=0 while in RUN and csn_out=1 otherwise.
REQ-017 The algorithm SHALL be March C-, with elements E0 up(w BG), E1 up(r BG,w ~BG), E2 up(r ~BG,w BG), E3 down(r BG,w ~BG), E4 down(r ~BG,w BG), E5 up(r BG).
REQ-018 E0 and E5 SHALL use one cycle per address; E1-E4 SHALL use two cycles per address (read, then write at the same address); total issue cycles N = 10*2^AW.
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on the rising edge of b_en.
- RUN->DRAIN after the last E5 read is issued.
- DRAIN->DONE after RD_LAT cycles.
- Any state->IDLE when b_en=0.
REQ-020 The address counter SHALL start at 0 for up elements and at 2^AW-1 for down elements, and wrap-around SHALL never be used to terminate an element; termination is detected at the terminal address.
REQ-021 Each read SHALL push {valid, expected, addr, elem} into an RD_LAT-deep delay line; compare SHALL occur when the delayed valid=1, against sram_data_in.
REQ-022 On the first miscompare, b_fail SHALL be set and fail_addr/fail_elem captured in the same cycle; later miscompares SHALL NOT alter the captured values.
REQ-023 If STOP_ON_FAIL=1, the FSM SHALL go RUN->DRAIN on the first miscompare, and b_done SHALL assert RD_LAT+1 cycles later.
REQ-024 b_done SHALL go high at edge N+RD_LAT+1 after the start edge (STOP_ON_FAIL=0) and SHALL hold while b_en=1.
REQ-025 A new test SHALL require b_en low for at least one cycle.
REQ-026 Dropping b_en mid-test SHALL abort to IDLE and clear b_done, b_fail, fail_addr and fail_elem at the next edge.
REQ-027 A miscompare in the same cycle as the RUN->DRAIN transition SHALL still be captured.

Reset
REQ-028 b_rst=1 SHALL force IDLE, clear the delay line, and set b_done=0, b_fail=0, fail_addr=0, fail_elem=0 at the next edge, including mid-test.
REQ-029 When b_rst=1 and b_en=1 in the same cycle, reset SHALL win, and the test SHALL NOT start until a fresh b_en rising edge after reset release.

Structure
REQ-030 Package mbist_pkg SHALL hold the FSM state enum, the 3-bit element encoding, and the March table (direction, read polarity, write polarity, has-read, has-write per element).
REQ-031 The delay line SHALL be sub-module mbist_cmp_pipe, parametrised by RD_LAT and payload width.
REQ-032 All other logic (FSM, address/element/phase counters, mux, fail capture) SHALL reside in mbist_march.

Verification (AW=4, DW=8, RD_LAT=1, BG=8'h00 unless stated)
REQ-033 Fault-free model, b_en 0->1: b_done rises at edge 162; b_fail=0; E0 writes addresses 0..15 with 8'h00; E3 issues addresses 15 down to 0.
REQ-034 Stuck-at-1 on bit 0 at address 5: b_fail=1, fail_addr=5, fail_elem=1, b_done still at edge 162.
REQ-035 STOP_ON_FAIL=1 with the same fault: RUN exits at the E1 read of address 5, b_done follows 2 cycles later, and no writes are issued afterwards.
REQ-036 b_en dropped at cycle 50: addr_out=addr_in in the same cycle; b_done=0 and b_fail=0 next edge; re-raising b_en reruns the full test.
REQ-037 b_rst pulsed at cycle 80 with b_en held high: IDLE, outputs cleared, no restart until b_en toggles.
REQ-038 RD_LAT=3 with BG=8'hA5: b_done at edge 164; the compare uses data delayed 3 cycles, with zero false fails.
